// File: rtl/q100_wb_if.sv
// MEM->WB stage bus: instruction fields and data from MEM, plus the
// register-file read port used by ID and the forwarding/CSR/counter outputs.
// Ports: slave = WB stage (the q100_wb block); master = surrounding pipeline.
interface q100_wb_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
);
  // MEM -> WB instruction/data
  logic                 retire_i;
  logic                 WB_i;
  logic                 CSR_i;
  logic [6:0]           opcode_i;
  logic [2:0]           funct3_i;
  logic                 wb_sel_i;
  logic [XLEN-1:0]      alu_result_i;
  logic [XLEN-1:0]      dtcm_rd_data_i;
  logic [XLEN-1:0]      csr_value_i;
  logic [11:0]          csr_addr_i;
  logic [4:0]           rd_i;
  // ID read ports
  logic [4:0]           rs1_addr_i;
  logic [4:0]           rs2_addr_i;
  logic [XLEN-1:0]      rs1_data_o;
  logic [XLEN-1:0]      rs2_data_o;
  // forwarding
  logic                 wb_en_o;
  logic [4:0]           wb_rd_o;
  logic [XLEN-1:0]      wb_data_o;
  // CSR write port and counters
  logic                 csr_wr_en_o;
  logic [11:0]          csr_wr_addr_o;
  logic [XLEN-1:0]      csr_wr_data_o;
  logic [CNT_WIDTH-1:0] mcycle_o;
  logic [CNT_WIDTH-1:0] minstret_o;

  modport slave (
    input  retire_i, WB_i, CSR_i, opcode_i, funct3_i, wb_sel_i, alu_result_i,
           dtcm_rd_data_i, csr_value_i, csr_addr_i, rd_i, rs1_addr_i, rs2_addr_i,
    output rs1_data_o, rs2_data_o, wb_en_o, wb_rd_o, wb_data_o,
           csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o, mcycle_o, minstret_o
  );

  modport master (
    output retire_i, WB_i, CSR_i, opcode_i, funct3_i, wb_sel_i, alu_result_i,
           dtcm_rd_data_i, csr_value_i, csr_addr_i, rd_i, rs1_addr_i, rs2_addr_i,
    input  rs1_data_o, rs2_data_o, wb_en_o, wb_rd_o, wb_data_o,
           csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o, mcycle_o, minstret_o
  );
endinterface

// File: rtl/q100_wb.sv
// RV32I write-back stage: result select, load align/extend, 32x32 regfile, mcycle/minstret.
// Latency: regfile/counters update at the next posedge; read ports and forwarding are combinational.
// Backpressure: none, WB always accepts; retire_i=0 marks a bubble and suppresses all writes.
// Ports: clk, rst (sync, active high), bus (q100_wb_if.slave) carrying MEM inputs,
// ID read ports, forwarding outputs, CSR write port and the 64-bit counters.
module q100_wb #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic     clk,
  input  logic     rst,
  q100_wb_if.slave bus
);

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  logic [XLEN-1:0]      rf_q [NUM_REGS];
  logic [XLEN-1:0]      rf_d [NUM_REGS];
  logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
  logic [CNT_WIDTH-1:0] minstret_q, minstret_d;

  logic            we;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_data;
  logic            csr_acc;
  logic            cnt_addr;

  // opcode is carried for debug/trace only; the write-back decode needs only funct3
  logic unused_opcode;
  assign unused_opcode = ^bus.opcode_i;

  assign we = bus.retire_i & bus.WB_i & (bus.rd_i != 5'd0) & ~rst;

  // load alignment: byte picked by the full offset, half by off[1] only
  always_comb begin
    ld_byte = bus.dtcm_rd_data_i[7:0];
    case (bus.alu_result_i[1:0])
      2'd0: ld_byte = bus.dtcm_rd_data_i[7:0];
      2'd1: ld_byte = bus.dtcm_rd_data_i[15:8];
      2'd2: ld_byte = bus.dtcm_rd_data_i[23:16];
      2'd3: ld_byte = bus.dtcm_rd_data_i[31:24];
      default: ld_byte = bus.dtcm_rd_data_i[7:0];
    endcase
    ld_half = bus.alu_result_i[1] ? bus.dtcm_rd_data_i[31:16] : bus.dtcm_rd_data_i[15:0];
    case (bus.funct3_i)
      3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
      default: load_val = bus.dtcm_rd_data_i;
    endcase
  end

  always_comb begin
    if (bus.CSR_i)        wb_data = bus.csr_value_i;
    else if (bus.wb_sel_i) wb_data = load_val;
    else                  wb_data = bus.alu_result_i;
  end

  assign bus.wb_en_o   = we;
  assign bus.wb_rd_o   = bus.rd_i;
  assign bus.wb_data_o = wb_data;

  // read ports: x0 hardwired, same-cycle write bypassed through
  always_comb begin
    if (bus.rs1_addr_i == 5'd0)                 bus.rs1_data_o = '0;
    else if (we && bus.rs1_addr_i == bus.rd_i)  bus.rs1_data_o = wb_data;
    else                                        bus.rs1_data_o = rf_q[bus.rs1_addr_i];
    if (bus.rs2_addr_i == 5'd0)                 bus.rs2_data_o = '0;
    else if (we && bus.rs2_addr_i == bus.rd_i)  bus.rs2_data_o = wb_data;
    else                                        bus.rs2_data_o = rf_q[bus.rs2_addr_i];
  end

  always_comb begin
    rf_d = rf_q;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_d[i] = '0;
    end else if (we) begin
      rf_d[bus.rd_i] = wb_data;
    end
  end

  // CSR port: counter addresses are owned locally and never reach the CSR file
  assign csr_acc  = bus.retire_i & bus.CSR_i;
  assign cnt_addr = (bus.csr_addr_i == CSR_MCYCLE)   || (bus.csr_addr_i == CSR_MCYCLEH) ||
                    (bus.csr_addr_i == CSR_MINSTRET) || (bus.csr_addr_i == CSR_MINSTRETH);

  assign bus.csr_wr_en_o   = csr_acc & ~rst & ~cnt_addr;
  assign bus.csr_wr_addr_o = bus.csr_addr_i;
  assign bus.csr_wr_data_o = bus.alu_result_i;

  // a counter write replaces that cycle's increment; the untouched half is held
  always_comb begin
    mcycle_d = mcycle_q + 1'b1;
    if (rst)
      mcycle_d = '0;
    else if (csr_acc && bus.csr_addr_i == CSR_MCYCLE)
      mcycle_d = {mcycle_q[CNT_WIDTH-1:32], bus.alu_result_i};
    else if (csr_acc && bus.csr_addr_i == CSR_MCYCLEH)
      mcycle_d = {bus.alu_result_i, mcycle_q[31:0]};
  end

  always_comb begin
    minstret_d = minstret_q;
    if (rst)
      minstret_d = '0;
    else if (csr_acc && bus.csr_addr_i == CSR_MINSTRET)
      minstret_d = {minstret_q[CNT_WIDTH-1:32], bus.alu_result_i};
    else if (csr_acc && bus.csr_addr_i == CSR_MINSTRETH)
      minstret_d = {bus.alu_result_i, minstret_q[31:0]};
    else if (bus.retire_i)
      minstret_d = minstret_q + 1'b1;
  end

  assign bus.mcycle_o   = mcycle_q;
  assign bus.minstret_o = minstret_q;

  always_ff @(posedge clk) begin
    rf_q       <= rf_d;
    mcycle_q   <= mcycle_d;
    minstret_q <= minstret_d;
  end

endmodule

// File: tb/tb_q100_wb.sv
// Directed bench for q100_wb: table of write-back select/load-align vectors,
// plus hand sequences for x0, bypass, counter CSR writes, wrap, bubbles and reset.
// Inputs change 1ns after posedge; outputs are sampled 1-2ns after posedge.
module tb_q100_wb;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  q100_wb_if bus ();

  q100_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        sel;
    logic        csr;
    logic [11:0] caddr;
    logic [31:0] alu;
    logic [31:0] dtcm;
    logic [31:0] csrv;
    logic [31:0] exp_data;
    logic        exp_csr_en;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ret, input logic wb, input logic csr, input logic [2:0] f3,
                       input logic sel, input logic [31:0] alu, input logic [31:0] dtcm,
                       input logic [31:0] csrv, input logic [11:0] ca, input logic [4:0] rd);
    bus.retire_i       = ret;
    bus.WB_i           = wb;
    bus.CSR_i          = csr;
    bus.opcode_i       = csr ? 7'h73 : (sel ? 7'h03 : 7'h13);
    bus.funct3_i       = f3;
    bus.wb_sel_i       = sel;
    bus.alu_result_i   = alu;
    bus.dtcm_rd_data_i = dtcm;
    bus.csr_value_i    = csrv;
    bus.csr_addr_i     = ca;
    bus.rd_i           = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 12'h000, 5'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //             f3      sel   csr   caddr    alu           dtcm          csrv          exp           csr_en
    vecs[0]  = '{3'b000, 1'b1, 1'b0, 12'h000, 32'h00000003, 32'h80FF7F01, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[1]  = '{3'b100, 1'b1, 1'b0, 12'h000, 32'h00000003, 32'h80FF7F01, 32'h0,        32'h00000080, 1'b0};
    vecs[2]  = '{3'b001, 1'b1, 1'b0, 12'h000, 32'h00000002, 32'h80FF7F01, 32'h0,        32'hFFFF80FF, 1'b0};
    vecs[3]  = '{3'b101, 1'b1, 1'b0, 12'h000, 32'h00000003, 32'h80FF7F01, 32'h0,        32'h000080FF, 1'b0};
    vecs[4]  = '{3'b000, 1'b1, 1'b0, 12'h000, 32'h00001001, 32'h80FF7F01, 32'h0,        32'h0000007F, 1'b0};
    vecs[5]  = '{3'b000, 1'b1, 1'b0, 12'h000, 32'h00001000, 32'h80FF7F01, 32'h0,        32'h00000001, 1'b0};
    vecs[6]  = '{3'b001, 1'b1, 1'b0, 12'h000, 32'h00000000, 32'h80FF7F01, 32'h0,        32'h00007F01, 1'b0};
    vecs[7]  = '{3'b101, 1'b1, 1'b0, 12'h000, 32'h00000001, 32'h80FF7F01, 32'h0,        32'h00007F01, 1'b0};
    vecs[8]  = '{3'b010, 1'b1, 1'b0, 12'h000, 32'h00000003, 32'h80FF7F01, 32'h0,        32'h80FF7F01, 1'b0};
    vecs[9]  = '{3'b011, 1'b1, 1'b0, 12'h000, 32'h00000001, 32'h12345678, 32'h0,        32'h12345678, 1'b0};
    vecs[10] = '{3'b000, 1'b0, 1'b0, 12'h000, 32'hA5A55A5B, 32'h80FF7F01, 32'h0,        32'hA5A55A5B, 1'b0};
    vecs[11] = '{3'b010, 1'b1, 1'b1, 12'h305, 32'h00000088, 32'h80FF7F01, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};

    // initial reset
    rst = 1'b1;
    idle();
    bus.rs1_addr_i = 5'd0;
    bus.rs2_addr_i = 5'd0;
    tick();
    tick();
    chk("rst_mcycle", bus.mcycle_o, 64'd0);
    chk("rst_minstret", bus.minstret_o, 64'd0);
    bus.rs1_addr_i = 5'd5;
    #1;
    chk("rst_x5", {32'd0, bus.rs1_data_o}, 64'd0);
    rst = 1'b0;
    tick();
    chk("mcycle_first", bus.mcycle_o, 64'd1);

    // table: write-back select and load alignment, written to x5
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, vecs[i].csr, vecs[i].f3, vecs[i].sel, vecs[i].alu, vecs[i].dtcm,
            vecs[i].csrv, vecs[i].caddr, 5'd5);
      bus.rs1_addr_i = 5'd0;
      #1;
      chk($sformatf("v%0d_wb_data", i), {32'd0, bus.wb_data_o}, {32'd0, vecs[i].exp_data});
      chk($sformatf("v%0d_wb_en", i), {63'd0, bus.wb_en_o}, 64'd1);
      chk($sformatf("v%0d_csr_en", i), {63'd0, bus.csr_wr_en_o}, {63'd0, vecs[i].exp_csr_en});
      if (vecs[i].exp_csr_en)
        chk($sformatf("v%0d_csr_data", i), {32'd0, bus.csr_wr_data_o}, {32'd0, vecs[i].alu});
      tick();
      idle();
      bus.rs1_addr_i = 5'd5;
      #1;
      chk($sformatf("v%0d_x5", i), {32'd0, bus.rs1_data_o}, {32'd0, vecs[i].exp_data});
    end

    // x0 write is dropped
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 32'h00001234, 32'h0, 32'h0, 12'h000, 5'd0);
    bus.rs1_addr_i = 5'd0;
    #1;
    chk("x0_wb_en", {63'd0, bus.wb_en_o}, 64'd0);
    tick();
    idle();
    #1;
    chk("x0_read", {32'd0, bus.rs1_data_o}, 64'd0);

    // same-cycle bypass on both read ports
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 12'h000, 5'd7);
    bus.rs1_addr_i = 5'd7;
    bus.rs2_addr_i = 5'd7;
    #1;
    chk("bypass_rs1", {32'd0, bus.rs1_data_o}, 64'hDEADBEEF);
    chk("bypass_rs2", {32'd0, bus.rs2_data_o}, 64'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("x7_stored", {32'd0, bus.rs2_data_o}, 64'hDEADBEEF);

    // minstret write overrides the increment
    drive(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 32'h5, 32'h0, 32'h0, 12'hB02, 5'd0);
    #1;
    chk("b02_csr_en", {63'd0, bus.csr_wr_en_o}, 64'd0);
    tick();
    chk("minstret_wr", bus.minstret_o, 64'd5);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 12'h000, 5'd0);
    tick();
    tick();
    tick();
    chk("minstret_3ret", bus.minstret_o, 64'd8);

    // mcycle preload to all ones, then wrap
    drive(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 12'hB00, 5'd0);
    #1;
    chk("b00_csr_en", {63'd0, bus.csr_wr_en_o}, 64'd0);
    tick();
    chk("mcycle_lo", {32'd0, bus.mcycle_o[31:0]}, 64'hFFFFFFFF);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 12'hB80, 5'd0);
    tick();
    chk("mcycle_all1", bus.mcycle_o, 64'hFFFFFFFF_FFFFFFFF);
    chk("minstret_csr2", bus.minstret_o, 64'd10);
    idle();
    tick();
    chk("mcycle_wrap", bus.mcycle_o, 64'd0);

    // bubble: no regfile write, minstret holds, mcycle counts
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 32'h00000055, 32'h0, 32'h0, 12'h000, 5'd9);
    bus.rs1_addr_i = 5'd9;
    #1;
    chk("bubble_wb_en", {63'd0, bus.wb_en_o}, 64'd0);
    chk("bubble_bypass", {32'd0, bus.rs1_data_o}, 64'd0);
    tick();
    idle();
    #1;
    chk("bubble_x9", {32'd0, bus.rs1_data_o}, 64'd0);
    chk("bubble_minstret", bus.minstret_o, 64'd10);
    chk("bubble_mcycle", bus.mcycle_o, 64'd1);

    // random writes, then reset with a live write and CSR access on the bus
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, $urandom | 32'h1, 32'h0, 32'h0, 12'h000,
            5'($urandom_range(1, 31)));
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 32'h77, 32'h0, 32'h99, 12'h300, 5'd3);
    #1;
    chk("rst_wb_en", {63'd0, bus.wb_en_o}, 64'd0);
    chk("rst_csr_en", {63'd0, bus.csr_wr_en_o}, 64'd0);
    tick();
    tick();
    for (int r = 1; r < 32; r++) begin
      bus.rs1_addr_i = 5'(r);
      bus.rs2_addr_i = 5'(32 - r);
      #1;
      chk($sformatf("rst_rs1_x%0d", r), {32'd0, bus.rs1_data_o}, 64'd0);
      chk($sformatf("rst_rs2_x%0d", 32 - r), {32'd0, bus.rs2_data_o}, 64'd0);
    end
    chk("rst2_mcycle", bus.mcycle_o, 64'd0);
    chk("rst2_minstret", bus.minstret_o, 64'd0);
    rst = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
